mem_stage: RTL and testbench

Memory stage of the pipeline, directly downstream of the EXE stage. Takes the EXE/MEM register contents (ALU result, store value, control bits, destination register) and performs the data-memory load or store over a ready/valid handshake to an external data memory of variable latency. Freezes the upstream pipeline while an access is outstanding, bounded by a timeout. Owns the MEM/WB pipeline register.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_wb_reg.sv | 58 +++++
 rtl/mem_stage.sv | 129 ++++++++++++
 tb/tb_mem_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_stage_pkg
// Brief    : Shared widths and FSM state encodings for the memory stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

    localparam int DEFAULT_WORD_LEN          = 32;
    localparam int DEFAULT_REG_FILE_ADDR_LEN = 5;
    localparam int DEFAULT_TIMEOUT           = 255;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Width of the wait counter; it never needs to hold more than TIMEOUT-1.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
//------------------------------------------------------------------------------
// Module   : mem_wb_reg
// Brief    : MEM/WB pipeline register with synchronous reset and bubble insert.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_reg #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bubble_i,
    input  logic                    wb_en_i,
    input  logic                    mem_r_en_i,
    input  logic [REG_ADDR_LEN-1:0] dest_i,
    input  logic [WORD_LEN-1:0]     alu_res_i,
    input  logic [WORD_LEN-1:0]     mem_data_i,
    output logic                    wb_en_o,
    output logic                    mem_r_en_o,
    output logic [REG_ADDR_LEN-1:0] dest_o,
    output logic [WORD_LEN-1:0]     alu_res_o,
    output logic [WORD_LEN-1:0]     mem_data_o
);

    logic                    wb_en_q;
    logic                    mem_r_en_q;
    logic [REG_ADDR_LEN-1:0] dest_q;
    logic [WORD_LEN-1:0]     alu_res_q;
    logic [WORD_LEN-1:0]     mem_data_q;

    // A bubble is a fully zeroed slot so WB sees a harmless no-op.
    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= '0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
        end else begin
            wb_en_q    <= wb_en_i;
            mem_r_en_q <= mem_r_en_i;
            dest_q     <= dest_i;
            alu_res_q  <= alu_res_i;
            mem_data_q <= mem_data_i;
        end
    end

    assign wb_en_o    = wb_en_q;
    assign mem_r_en_o = mem_r_en_q;
    assign dest_o     = dest_q;
    assign alu_res_o  = alu_res_q;
    assign mem_data_o = mem_data_q;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module   : mem_stage
// Brief    : Pipeline memory stage: handshaked data-memory access with freeze,
//            timeout abort and the MEM/WB register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_LEN     = DEFAULT_WORD_LEN,
    parameter int REG_ADDR_LEN = DEFAULT_REG_FILE_ADDR_LEN,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic                    WB_EN_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [WORD_LEN-1:0]     ALU_res_in,
    input  logic [WORD_LEN-1:0]     ST_value_in,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [WORD_LEN-1:0]     mem_addr,
    output logic [WORD_LEN-1:0]     mem_wdata,
    input  logic [WORD_LEN-1:0]     mem_rdata,
    input  logic                    mem_ready,
    output logic                    freeze,
    output logic                    mem_err,
    output logic                    WB_EN_out,
    output logic                    MEM_R_EN_out,
    output logic [REG_ADDR_LEN-1:0] dest_out,
    output logic [WORD_LEN-1:0]     ALU_res_out,
    output logic [WORD_LEN-1:0]     mem_data_out
);

    localparam int               CNT_W    = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              access;
    logic              timeout_hit;
    logic              wb_en_d;
    logic [WORD_LEN-1:0] mem_data_d;

    assign access = MEM_R_EN | MEM_W_EN;

    // Counter is 0 in IDLE, so with TIMEOUT==1 the request cycle itself aborts.
    assign timeout_hit = access & ~mem_ready & (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | timeout_hit;
        case (state_q)
            MEM_IDLE: begin
                cnt_d = '0;
                if (access && !mem_ready && !timeout_hit) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                // Leaving on a dropped request keeps the counter from wrapping.
                if (!access || mem_ready || timeout_hit) begin
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_req    = ~rst & access;
        mem_we     = MEM_W_EN;
        mem_addr   = {ALU_res_in[WORD_LEN-1:2], 2'b00};
        mem_wdata  = ST_value_in;
        freeze     = mem_req & ~mem_ready & ~timeout_hit;
        mem_err    = err_q;
        wb_en_d    = WB_EN_in & ~timeout_hit;
        mem_data_d = (MEM_R_EN && mem_ready) ? mem_rdata : '0;
    end

    mem_wb_reg #(
        .WORD_LEN     (WORD_LEN),
        .REG_ADDR_LEN (REG_ADDR_LEN)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .bubble_i   (freeze),
        .wb_en_i    (wb_en_d),
        .mem_r_en_i (MEM_R_EN),
        .dest_i     (dest_in),
        .alu_res_i  (ALU_res_in),
        .mem_data_i (mem_data_d),
        .wb_en_o    (WB_EN_out),
        .mem_r_en_o (MEM_R_EN_out),
        .dest_o     (dest_out),
        .alu_res_o  (ALU_res_out),
        .mem_data_o (mem_data_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_stage
// Brief    : Self-checking bench for mem_stage (directed table, corner
//            sequences, and randomized transactions against a reference model).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN, WB_EN_in;
    logic [4:0]  dest_in;
    logic [31:0] ALU_res_in, ST_value_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready, freeze, mem_err;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [4:0]  dest_out;
    logic [31:0] ALU_res_out, mem_data_out;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .WORD_LEN     (32),
        .REG_ADDR_LEN (5),
        .TIMEOUT      (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .WB_EN_in     (WB_EN_in),
        .dest_in      (dest_in),
        .ALU_res_in   (ALU_res_in),
        .ST_value_in  (ST_value_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .freeze       (freeze),
        .mem_err      (mem_err),
        .WB_EN_out    (WB_EN_out),
        .MEM_R_EN_out (MEM_R_EN_out),
        .dest_out     (dest_out),
        .ALU_res_out  (ALU_res_out),
        .mem_data_out (mem_data_out)
    );

    // One instruction: its inputs, memory latency (cycles after the request
    // cycle until ready), and the expected outcome.
    typedef struct {
        logic        ren;
        logic        wen;
        logic        wb;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] rdata;
        int          lat;
        int          e_frz;
        logic        e_wb;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bubble();
        chk("bubble_wb_en",  {31'd0, WB_EN_out},    32'd0);
        chk("bubble_r_en",   {31'd0, MEM_R_EN_out}, 32'd0);
        chk("bubble_dest",   {27'd0, dest_out},     32'd0);
        chk("bubble_alu",    ALU_res_out,           32'd0);
        chk("bubble_data",   mem_data_out,          32'd0);
    endtask

    task automatic drive_ready(input vec_t v, input int k);
        mem_ready = (k == v.lat);
        mem_rdata = mem_ready ? v.rdata : $urandom;
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic run_instr(input vec_t v);
        bit done = 0;
        logic acc;
        MEM_R_EN    = v.ren;
        MEM_W_EN    = v.wen;
        WB_EN_in    = v.wb;
        dest_in     = v.dest;
        ALU_res_in  = v.alu;
        ST_value_in = v.st;
        acc = v.ren | v.wen;
        drive_ready(v, 0);
        for (int k = 0; k < 64 && !done; k++) begin
            #1;
            chk("mem_req",   {31'd0, mem_req}, {31'd0, acc});
            chk("freeze",    {31'd0, freeze},  {31'd0, (k < v.e_frz)});
            chk("mem_addr",  mem_addr,  {v.alu[31:2], 2'b00});
            chk("mem_wdata", mem_wdata, v.st);
            if (acc) chk("mem_we", {31'd0, mem_we}, {31'd0, v.wen});
            @(posedge clk);
            #1;
            if (k < v.e_frz) begin
                chk_bubble();
                drive_ready(v, k + 1);
            end else begin
                chk("wb_en_out",    {31'd0, WB_EN_out},    {31'd0, v.e_wb});
                chk("mem_r_en_out", {31'd0, MEM_R_EN_out}, {31'd0, v.ren});
                chk("dest_out",     {27'd0, dest_out},     {27'd0, v.dest});
                chk("alu_res_out",  ALU_res_out,           v.alu);
                chk("mem_data_out", mem_data_out,          v.e_data);
                done = 1;
            end
        end
        if (!done) chk("instr_completes", 32'd0, 32'd1);
        chk("mem_err", {31'd0, mem_err}, {31'd0, v.e_err});
    endtask

    vec_t tbl[8];
    vec_t rv;
    bit   err_m;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           ren  wen  wb   dest  alu           st            rdata         lat frz wb  data          err
        tbl[0] = '{1'b0,1'b0,1'b1,5'd3, 32'h0000_0010,32'h0,        32'h5555_AAAA,0, 0,1'b1,32'h0,        1'b0};
        tbl[1] = '{1'b1,1'b0,1'b1,5'd7, 32'h0000_0403,32'h0,        32'hDEAD_BEEF,0, 0,1'b1,32'hDEAD_BEEF,1'b0};
        tbl[2] = '{1'b0,1'b1,1'b0,5'd0, 32'h0000_0100,32'h0000_1234,32'h0,        3, 3,1'b0,32'h0,        1'b0};
        tbl[3] = '{1'b1,1'b0,1'b1,5'd5, 32'h0000_0020,32'h0,        32'h1111_1111,2, 2,1'b1,32'h1111_1111,1'b0};
        tbl[4] = '{1'b1,1'b0,1'b1,5'd6, 32'h0000_0025,32'h0,        32'h2222_2222,2, 2,1'b1,32'h2222_2222,1'b0};
        tbl[5] = '{1'b1,1'b0,1'b1,5'd9, 32'h0000_0080,32'h0,        32'h3333_3333,9, 3,1'b0,32'h0,        1'b1};
        tbl[6] = '{1'b0,1'b1,1'b1,5'd4, 32'h0000_0044,32'h0000_CAFE,32'h0,        1, 1,1'b1,32'h0,        1'b1};
        tbl[7] = '{1'b1,1'b0,1'b1,5'd8, 32'h0000_0F0F,32'h0,        32'h4444_4444,3, 3,1'b1,32'h4444_4444,1'b1};

        // Reset with a pending-looking load: no request, no freeze, all zero.
        rst = 1'b1;
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; WB_EN_in = 1'b1;
        dest_in = 5'd1; ALU_res_in = 32'h10; ST_value_in = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_freeze",  {31'd0, freeze},  32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk_bubble();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_instr(tbl[i]);

        // Reset in the second wait cycle of a load abandons it and clears mem_err.
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; WB_EN_in = 1'b1;
        dest_in = 5'd12; ALU_res_in = 32'h200; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstw_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstw_freeze",  {31'd0, freeze},  32'd0);
        @(posedge clk); #1;
        chk("rstw_mem_err", {31'd0, mem_err}, 32'd0);
        chk_bubble();
        rst = 1'b0;
        rv = '{1'b1,1'b0,1'b1,5'd13,32'h0000_0300,32'h0,32'h5A5A_0001,1,1,1'b1,32'h5A5A_0001,1'b0};
        run_instr(rv);

        // Randomized transactions checked against a per-instruction model.
        err_m = 1'b0;
        for (int n = 0; n < 200; n++) begin
            int   kind;
            logic acc;
            bit   tmo;
            kind     = $urandom_range(0, 2);
            rv.ren   = (kind == 1);
            rv.wen   = (kind == 2);
            rv.wb    = 1'($urandom);
            rv.dest  = 5'($urandom);
            rv.alu   = $urandom;
            rv.st    = $urandom;
            rv.rdata = $urandom;
            rv.lat   = $urandom_range(0, TO + 1);
            acc      = rv.ren | rv.wen;
            tmo      = acc && (rv.lat >= TO);
            rv.e_frz = !acc ? 0 : (tmo ? TO - 1 : rv.lat);
            rv.e_wb  = rv.wb & !tmo;
            rv.e_data = (rv.ren && !tmo) ? rv.rdata : 32'h0;
            err_m    = err_m | tmo;
            rv.e_err = err_m;
            run_instr(rv);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
